// File: rtl/vacc_pkg.sv
// Shared vector-accelerator definitions: opcodes, sequencer states and instruction fields.
package vacc_pkg;

  typedef enum logic [3:0] {
    OpNop = 4'h0,
    OpLdv = 4'h1,
    OpLds = 4'h2,
    OpRed = 4'h3,
    OpStv = 4'h4
  } opcode_e;

  typedef enum logic [4:0] {
    StFetchHi, StFetchLo, StDecode,
    StLdvLoad, StLdvStream, StLdvWrite,
    StLdsWait, StLdsWrite,
    StRedRead, StRedWait, StRedWrite,
    StAluRead, StAluWrite,
    StStvRead, StStvOut, StStvWait,
    StErr
  } state_e;

  localparam int unsigned OP_MSB    = 15;
  localparam int unsigned OP_LSB    = 12;
  localparam int unsigned DST_MSB   = 11;
  localparam int unsigned DST_LSB   = 8;
  localparam int unsigned SRC_A_MSB = 7;
  localparam int unsigned SRC_A_LSB = 4;
  localparam int unsigned SRC_B_MSB = 3;
  localparam int unsigned SRC_B_LSB = 0;
  // Reduction op lives in the low bits of the srcB field.
  localparam int unsigned RED_OP_MSB = 2;

  localparam logic [3:0] SRC_SCAL = 4'hF;
  localparam logic [2:0] ALU_PASS = 3'b000;

  // Opcodes 0x8-0xF are all element-wise ALU ops.
  function automatic logic is_alu_op(logic [3:0] op);
    return op[3];
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Wait-state watchdog: flags a wait that has lasted Limit cycles without completing.
module seq_watchdog #(
  parameter int unsigned Limit = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  output logic expired
);

  localparam int unsigned CntW = $clog2(Limit + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = active ? cnt_q + 1'b1 : '0;
  end

  // Fires on the last permitted wait cycle so the sequencer leaves right after it.
  assign expired = active && (cnt_q == CntW'(Limit - 1));

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/inst_sequencer.sv
// Instruction sequencer for the vector datapath: fetch, decode and per-op strobe sequencing.
// Define SEQ_TIMEOUT_EN to abort stalled waits to the error state after 4*N cycles.
module inst_sequencer
  import vacc_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        host_valid,
  output logic        host_ready,
  output logic        out_valid,
  input  logic [15:0] inst,
  input  logic        vec_imm_buff_done,
  input  logic        red_alu_done,
  input  logic        vec_out_buff_done,
  output logic [3:0]  vec_sel_a,
  output logic [3:0]  vec_sel_b,
  output logic [2:0]  alu_op_sel,
  output logic        alu_scal_sel,
  output logic        set_inst_hi,
  output logic        set_inst_lo,
  output logic        set_vec_imm_buff_vec,
  output logic        set_vec_imm_buff_scal,
  output logic        set_scal_imm_buff,
  output logic        set_vec_reg_bank,
  output logic        set_vec_alu,
  output logic        set_red_alu,
  output logic        set_scal_acc,
  output logic        set_vec_out_buff,
  output logic        en_vec_imm_buff,
  output logic        en_scal_imm_buff,
  output logic        en_vec_reg_bank_a,
  output logic        en_vec_reg_bank_b,
  output logic        en_vec_alu,
  output logic        en_red_alu,
  output logic        en_scal_acc,
  output logic        busy,
  output logic        err
);

  state_e state_q, state_d;
  logic [3:0] op, dst, src_a, src_b;
  logic       timeout;

  assign op    = inst[OP_MSB:OP_LSB];
  assign dst   = inst[DST_MSB:DST_LSB];
  assign src_a = inst[SRC_A_MSB:SRC_A_LSB];
  assign src_b = inst[SRC_B_MSB:SRC_B_LSB];

`ifdef SEQ_TIMEOUT_EN
  logic wait_active;
  assign wait_active = state_q inside {StLdvStream, StLdsWait, StRedWait, StStvWait};

  seq_watchdog #(
    .Limit(4 * N)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .active (wait_active),
    .expired(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d               = state_q;
    host_ready            = 1'b0;
    out_valid             = 1'b0;
    vec_sel_a             = '0;
    vec_sel_b             = '0;
    alu_op_sel            = '0;
    alu_scal_sel          = 1'b0;
    set_inst_hi           = 1'b0;
    set_inst_lo           = 1'b0;
    set_vec_imm_buff_vec  = 1'b0;
    set_vec_imm_buff_scal = 1'b0;
    set_scal_imm_buff     = 1'b0;
    set_vec_reg_bank      = 1'b0;
    set_vec_alu           = 1'b0;
    set_red_alu           = 1'b0;
    set_scal_acc          = 1'b0;
    set_vec_out_buff      = 1'b0;
    en_vec_imm_buff       = 1'b0;
    en_scal_imm_buff      = 1'b0;
    en_vec_reg_bank_a     = 1'b0;
    en_vec_reg_bank_b     = 1'b0;
    en_vec_alu            = 1'b0;
    en_red_alu            = 1'b0;
    en_scal_acc           = 1'b0;
    // The error state reports only err, so busy is suppressed there as well.
    busy                  = !rst && (state_q != StFetchHi) && (state_q != StErr);
    err                   = !rst && (state_q == StErr);

    if (!rst) begin
      unique case (state_q)
        StFetchHi: begin
          host_ready = 1'b1;
          if (host_valid) begin
            set_inst_hi = 1'b1;
            state_d     = StFetchLo;
          end
        end
        StFetchLo: begin
          host_ready = 1'b1;
          if (host_valid) begin
            set_inst_lo = 1'b1;
            state_d     = StDecode;
          end
        end
        StDecode: begin
          if (is_alu_op(op)) begin
            state_d = StAluRead;
          end else begin
            case (op)
              OpNop:   state_d = StFetchHi;
              OpLdv:   state_d = StLdvLoad;
              OpLds:   state_d = StLdsWait;
              OpRed:   state_d = StRedRead;
              OpStv:   state_d = StStvRead;
              default: state_d = StErr;
            endcase
          end
        end
        StLdvLoad: begin
          set_vec_imm_buff_vec = 1'b1;
          state_d              = StLdvStream;
        end
        StLdvStream: begin
          // Host must stream a byte every cycle until the buffer reports full.
          if (vec_imm_buff_done) begin
            state_d = StLdvWrite;
          end else begin
            host_ready = 1'b1;
            if (!host_valid || timeout) state_d = StErr;
          end
        end
        StLdvWrite: begin
          en_vec_imm_buff  = 1'b1;
          set_vec_reg_bank = 1'b1;
          vec_sel_a        = dst;
          state_d          = StFetchHi;
        end
        StLdsWait: begin
          host_ready = 1'b1;
          if (host_valid) begin
            set_scal_imm_buff = 1'b1;
            state_d           = StLdsWrite;
          end else if (timeout) begin
            state_d = StErr;
          end
        end
        StLdsWrite: begin
          en_scal_imm_buff = 1'b1;
          set_scal_acc     = 1'b1;
          state_d          = StFetchHi;
        end
        StRedRead: begin
          en_vec_reg_bank_a = 1'b1;
          set_red_alu       = 1'b1;
          vec_sel_a         = src_a;
          alu_op_sel        = inst[RED_OP_MSB:0];
          state_d           = StRedWait;
        end
        StRedWait: begin
          if (red_alu_done) state_d = StRedWrite;
          else if (timeout) state_d = StErr;
        end
        StRedWrite: begin
          en_red_alu   = 1'b1;
          set_scal_acc = 1'b1;
          state_d      = StFetchHi;
        end
        StAluRead: begin
          // A and B operands travel on separate buses, so one driver each is allowed.
          en_vec_reg_bank_a = 1'b1;
          set_vec_alu       = 1'b1;
          vec_sel_a         = src_a;
          alu_op_sel        = op[2:0];
          if (src_b == SRC_SCAL) begin
            en_scal_acc  = 1'b1;
            alu_scal_sel = 1'b1;
          end else begin
            en_vec_reg_bank_b = 1'b1;
            vec_sel_b         = src_b;
          end
          state_d = StAluWrite;
        end
        StAluWrite: begin
          en_vec_alu       = 1'b1;
          set_vec_reg_bank = 1'b1;
          vec_sel_a        = dst;
          state_d          = StFetchHi;
        end
        StStvRead: begin
          en_vec_reg_bank_a = 1'b1;
          set_vec_alu       = 1'b1;
          vec_sel_a         = src_a;
          alu_op_sel        = ALU_PASS;
          state_d           = StStvOut;
        end
        StStvOut: begin
          en_vec_alu       = 1'b1;
          set_vec_out_buff = 1'b1;
          state_d          = StStvWait;
        end
        StStvWait: begin
          out_valid = 1'b1;
          if (vec_out_buff_done) state_d = StFetchHi;
          else if (timeout)      state_d = StErr;
        end
        StErr: begin
          state_d = StErr;
        end
        default: begin
          state_d = StErr;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StFetchHi;
    else     state_q <= state_d;
  end

endmodule
